vga_sync_monitor: RTL and testbench
===================================

# vga_sync_monitor

Receive-side checker for the VGA timing generator: samples the active-low horizontal and vertical sync outputs, verifies line and frame timing against the configured 1600-cycle-line mode, and recovers display enable and pixel/line coordinates. It sits beside the sync generator on the same clock as a built-in self-check and coordinate source for downstream test-pattern and capture logic.

## Interface
- H_TOTAL, 1600, clk cycles per scanline
- H_PULSE, 192, hsync low width (cycles)
- H_BP, 96, back porch (cycles)
- H_DISP, 1280, display cycles per line
- V_TOTAL, 521, lines per frame
- V_PULSE, 2, vsync low width (lines)
- V_BP, 29, vertical back porch (lines)
- V_DISP, 480, display lines
- LOCK_LINES, 4, consecutive good lines required before lock
- clk  in  1  pixel-timing clock
- resetbutton  in  1  asynchronous, active-high reset
- vga_hsync  in  1  hsync under test, active low
- vga_vsync  in  1  vsync under test, active low
- locked  out  1  timing locked and frame-aligned
- de  out  1  recovered display enable
- pix_x  out  11  pixel column, valid while de
- pix_y  out  10  line row, valid while de
- frame_start  out  1  one-cycle pulse at each frame start while locked
- sync_err  out  1  one-cycle pulse on each failed check
- err_count  out  8  saturating count of failed checks

## Operation
- Inputs registered once; falling/rising edges detected against the previous sample ("fall"/"rise").
- h_cnt: cycles since last fall; width ceil(log2(2*H_TOTAL+1)); fall loads 0, otherwise increments, saturates at 2*H_TOTAL.
- Line check at each fall: pass iff distance from previous fall == H_TOTAL and the intervening rise occurred exactly H_PULSE cycles after the previous fall.
- vsync sampled at each fall. v_cnt (10 bits) increments per fall; vsync fall (high at previous fall, low now) loads 0.
- Frame check at each vsync fall: pass iff falls since previous vsync fall == V_TOTAL and vsync was low for exactly V_PULSE falls.
- FSM, reset state SEARCH:
  - SEARCH: first fall -> MEASURE, good_cnt=0.
  - MEASURE: passing line -> good_cnt++ (saturate at LOCK_LINES); failing line -> good_cnt=0, sync_err. good_cnt==LOCK_LINES and vsync fall -> LOCKED (frame check skipped for this first edge).
  - LOCKED: failing line or frame check -> sync_err, MEASURE, good_cnt=0.
  - Any state except SEARCH: h_cnt reaching 2*H_TOTAL -> SEARCH, no sync_err.
- err_count increments on every sync_err, saturates at 255, cleared only by reset.
- de = locked and h offset in [H_PULSE+H_BP, H_PULSE+H_BP+H_DISP-1] and v_cnt in [V_PULSE+V_BP, V_PULSE+V_BP+V_DISP-1].
- pix_x = h offset − (H_PULSE+H_BP); pix_y = v_cnt − (V_PULSE+V_BP); both held at 0 when de low.
- frame_start pulses at each vsync fall while in LOCKED (including the entry edge).

## Timing
- Reset: all outputs 0, FSM SEARCH, counters 0, applied asynchronously.
- Fall/rise detection: 2 cycles after the pin transition (input register + edge register).
- de, pix_x, pix_y, frame_start, sync_err, locked registered: 1 cycle after the detection cycle; de therefore rises exactly H_PULSE+H_BP cycles after the fall-detected cycle's output, aligned with pix_x=0.
- Fall and timeout in same cycle: fall wins.
- Line and frame failure on same fall: single sync_err, err_count +1.
- Reset mid-line: next fall treated as first fall (SEARCH -> MEASURE).

## Configuration
- VGA_SYNC_MON_SYNC_EN defined: both inputs pass through a two-flop synchronizer ahead of the input register; all input-to-output latencies grow by 2 cycles; reset clears synchronizer to 1 (idle high).
- Undefined: single input register only, latencies as in Timing.

## Test plan
- Ideal 1600/192 hsync with 521/2 vsync for 3 frames -> locked at first vsync fall after 4 lines; de 1280 cycles/line on 480 lines; pix_x 0..1279, pix_y 0..479; frame_start every 833600 cycles; err_count 0.
- While locked, one line of 1601 cycles -> one sync_err, err_count=1, locked 0, relocks at next vsync fall.
- While locked, hsync pulse 191 cycles -> sync_err, err_count=1, locked 0.
- Frame of 520 lines while locked -> sync_err at vsync fall, locked 0, frame_start absent for that edge.
- hsync held high 3200+ cycles -> FSM SEARCH, locked 0, de 0, err_count unchanged.
- 300 consecutive 1599-cycle lines -> err_count saturates at 255; resetbutton mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for the VGA sync generator.
// It samples active-low hsync/vsync, checks line and frame timing, locks
// after enough good lines plus a vsync fall, and recovers display enable
// and pixel/line coordinates for downstream logic.
// Optional build macro: VGA_SYNC_MON_SYNC_EN adds a two-flop synchronizer
// (reset to idle high) ahead of the input register, delaying all outputs
// by two extra cycles.
module vga_sync_monitor #(
  parameter int H_TOTAL    = 1600,
  parameter int H_PULSE    = 192,
  parameter int H_BP       = 96,
  parameter int H_DISP     = 1280,
  parameter int V_TOTAL    = 521,
  parameter int V_PULSE    = 2,
  parameter int V_BP       = 29,
  parameter int V_DISP     = 480,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        resetbutton,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic        locked,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam int HW = $clog2(2 * H_TOTAL + 1);
  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [HW-1:0] H_SAT       = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0] H_LINE_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_RISE_AT   = HW'(H_PULSE - 1);
  localparam logic [HW-1:0] H_DE_FIRST  = HW'(H_PULSE + H_BP);
  localparam logic [HW-1:0] H_DE_LAST   = HW'(H_PULSE + H_BP + H_DISP - 1);
  localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_PULSE_C   = 10'(V_PULSE);
  localparam logic [9:0]    V_DE_FIRST  = 10'(V_PULSE + V_BP);
  localparam logic [9:0]    V_DE_LAST   = 10'(V_PULSE + V_BP + V_DISP - 1);
  localparam logic [GW-1:0] GOOD_FULL   = GW'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic hs_src, vs_src;

`ifdef VGA_SYNC_MON_SYNC_EN
  logic hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d;
  logic vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d;

  // Synchronizer next values: plain two-stage shift of each pin.
  always_comb begin
    hs_meta_d = vga_hsync;
    hs_sync_d = hs_meta_q;
    vs_meta_d = vga_vsync;
    vs_sync_d = vs_meta_q;
  end

  // Synchronizer flops idle high so reset never looks like a sync pulse.
  always_ff @(posedge clk or posedge resetbutton) begin
    if (resetbutton) begin
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
    end else begin
      hs_meta_q <= hs_meta_d;
      hs_sync_q <= hs_sync_d;
      vs_meta_q <= vs_meta_d;
      vs_sync_q <= vs_sync_d;
    end
  end

  assign hs_src = hs_sync_q;
  assign vs_src = vs_sync_q;
`else
  assign hs_src = vga_hsync;
  assign vs_src = vga_vsync;
`endif

  logic hs_in_q, hs_in_d, hs_last_q, hs_last_d;
  logic vs_in_q, vs_in_d, vs_last_q, vs_last_d;
  logic fall_q, fall_d, rise_q, rise_d;

  // Input register, one-cycle history and registered hsync edge flags.
  always_comb begin
    hs_in_d   = hs_src;
    vs_in_d   = vs_src;
    hs_last_d = hs_in_q;
    vs_last_d = vs_in_q;
    fall_d    = hs_last_q & ~hs_in_q;
    rise_d    = ~hs_last_q & hs_in_q;
  end

  // Sampling pipeline; idle-high reset avoids a phantom edge after reset.
  always_ff @(posedge clk or posedge resetbutton) begin
    if (resetbutton) begin
      hs_in_q   <= 1'b1;
      vs_in_q   <= 1'b1;
      hs_last_q <= 1'b1;
      vs_last_q <= 1'b1;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      hs_in_q   <= hs_in_d;
      vs_in_q   <= vs_in_d;
      hs_last_q <= hs_last_d;
      vs_last_q <= vs_last_d;
      fall_q    <= fall_d;
      rise_q    <= rise_d;
    end
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d, rise_at_q, rise_at_d;
  logic          rise_seen_q, rise_seen_d;
  logic          vs_prev_fall_q, vs_prev_fall_d;
  logic [9:0]    v_cnt_q, v_cnt_d, vlow_cnt_q, vlow_cnt_d, vlow_len_q, vlow_len_d;
  logic          vfall, line_ok, frame_ok, timeout;

  // Horizontal/vertical measurement counters, all keyed off hsync falls.
  // vs_last_q is the vsync sample aligned with the hsync fall flag.
  always_comb begin
    h_cnt_d        = h_cnt_q;
    rise_at_d      = rise_at_q;
    rise_seen_d    = rise_seen_q;
    vs_prev_fall_d = vs_prev_fall_q;
    v_cnt_d        = v_cnt_q;
    vlow_cnt_d     = vlow_cnt_q;
    vlow_len_d     = vlow_len_q;
    vfall          = fall_q & vs_prev_fall_q & ~vs_last_q;
    line_ok        = (h_cnt_q == H_LINE_LAST) && rise_seen_q && (rise_at_q == H_RISE_AT);
    frame_ok       = (v_cnt_q == V_LAST) && (vlow_len_q == V_PULSE_C);
    timeout        = (h_cnt_q == H_SAT);
    if (fall_q) begin
      h_cnt_d        = '0;
      rise_seen_d    = 1'b0;
      vs_prev_fall_d = vs_last_q;
      if (vfall) begin
        v_cnt_d = '0;
      end else if (v_cnt_q != 10'h3FF) begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
      if (!vs_last_q) begin
        if (vfall) begin
          vlow_cnt_d = 10'd1;
        end else if (vlow_cnt_q != 10'h3FF) begin
          vlow_cnt_d = vlow_cnt_q + 10'd1;
        end
      end else if (!vs_prev_fall_q) begin
        vlow_len_d = vlow_cnt_q;
      end
    end else begin
      if (!timeout) begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      if (rise_q) begin
        rise_seen_d = 1'b1;
        rise_at_d   = h_cnt_q;
      end
    end
  end

  // Measurement registers.
  always_ff @(posedge clk or posedge resetbutton) begin
    if (resetbutton) begin
      h_cnt_q        <= '0;
      rise_at_q      <= '0;
      rise_seen_q    <= 1'b0;
      vs_prev_fall_q <= 1'b1;
      v_cnt_q        <= '0;
      vlow_cnt_q     <= '0;
      vlow_len_q     <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      rise_at_q      <= rise_at_d;
      rise_seen_q    <= rise_seen_d;
      vs_prev_fall_q <= vs_prev_fall_d;
      v_cnt_q        <= v_cnt_d;
      vlow_cnt_q     <= vlow_cnt_d;
      vlow_len_q     <= vlow_len_d;
    end
  end

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          err;

  // FSM state register.
  always_ff @(posedge clk or posedge resetbutton) begin
    if (resetbutton) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // FSM next state: a fall always takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err     = 1'b0;
    if (fall_q) begin
      unique case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          good_d  = '0;
        end
        MEASURE: begin
          if (line_ok) begin
            if (good_q != GOOD_FULL) good_d = good_q + 1'b1;
          end else begin
            good_d = '0;
            err    = 1'b1;
          end
          if (good_d == GOOD_FULL && vfall) state_d = LOCKED;
        end
        LOCKED: begin
          if (!line_ok || (vfall && !frame_ok)) begin
            state_d = MEASURE;
            good_d  = '0;
            err     = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end else if (state_q != SEARCH && timeout) begin
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  logic          locked_q, locked_d, de_q, de_d, frame_start_q, frame_start_d;
  logic          sync_err_q, sync_err_d;
  logic [10:0]   pix_x_q, pix_x_d;
  logic [9:0]    pix_y_q, pix_y_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [HW-1:0] h_off;
  logic [9:0]    v_off;

  // Outputs use next-cycle counter values so they line up with h_cnt_q.
  always_comb begin
    h_off         = h_cnt_d - H_DE_FIRST;
    v_off         = v_cnt_d - V_DE_FIRST;
    locked_d      = (state_d == LOCKED);
    de_d          = locked_d && (h_cnt_d >= H_DE_FIRST) && (h_cnt_d <= H_DE_LAST)
                    && (v_cnt_d >= V_DE_FIRST) && (v_cnt_d <= V_DE_LAST);
    pix_x_d       = de_d ? 11'(h_off) : 11'd0;
    pix_y_d       = de_d ? v_off : 10'd0;
    frame_start_d = vfall && (state_d == LOCKED);
    sync_err_d    = err;
    err_count_d   = err_count_q;
    if (err && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge resetbutton) begin
    if (resetbutton) begin
      locked_q      <= 1'b0;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      locked_q      <= locked_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = locked_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down timing mode
// (40-cycle lines, 12-line frames) so whole frames fit in a short run.
module tb_vga_sync_monitor;

  localparam int HT = 40, HP = 6, HB = 4, HD = 24;
  localparam int VT = 12, VP = 2, VB = 2, VD = 6, LL = 4;

  logic        clk = 1'b0;
  logic        resetbutton, vga_hsync, vga_vsync;
  logic        locked, de, frame_start, sync_err;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  err_count;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_PULSE(HP), .H_BP(HB), .H_DISP(HD),
    .V_TOTAL(VT), .V_PULSE(VP), .V_BP(VB), .V_DISP(VD), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .resetbutton(resetbutton), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .locked(locked), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int line_start_cyc = 0;
  int clear_gen = 0, seen_gen = 0;
  int de_total = 0, fs_count = 0, err_pulses = 0, x_max = 0, y_max = 0, pix_bad = 0;
  int fs_off = 0, err_off = 0, de_rise_off = 0, fs_period = 0, last_fs = 0;
  int exp_x = 0, exp_y = 0;
  bit de_prev = 1'b0, fs_flag = 1'b0;

  // Cycle counter advanced on each active edge.
  always @(posedge clk) cyc = cyc + 1;

  // Monitor gathers per-test statistics away from the active edge.
  always @(negedge clk) begin
    if (seen_gen != clear_gen) begin
      de_total = 0; fs_count = 0; err_pulses = 0;
      x_max = 0; y_max = 0; pix_bad = 0;
      seen_gen = clear_gen;
    end
    if (!resetbutton) begin
      if (frame_start) begin
        fs_count++;
        fs_off = cyc - line_start_cyc;
        if (last_fs > 0) fs_period = cyc - last_fs;
        last_fs = cyc;
        fs_flag = 1'b1;
      end
      if (sync_err) begin
        err_pulses++;
        err_off = cyc - line_start_cyc;
      end
      if (de) begin
        de_total++;
        if (!de_prev) begin
          de_rise_off = cyc - line_start_cyc;
          exp_x = 0;
          exp_y = fs_flag ? 0 : exp_y + 1;
          fs_flag = 1'b0;
        end else begin
          exp_x++;
        end
        if (int'(pix_x) != exp_x || int'(pix_y) != exp_y) pix_bad++;
        if (int'(pix_x) > x_max) x_max = int'(pix_x);
        if (int'(pix_y) > y_max) y_max = int'(pix_y);
      end else if (pix_x != 11'd0 || pix_y != 10'd0) begin
        pix_bad++;
      end
    end
    de_prev = de;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One scanline: hsync low for 'pulse' cycles, vsync level held for the line.
  task automatic applyStimulus(input int len, input int pulse, input bit vlow);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) line_start_cyc = cyc;
      vga_hsync = (i >= pulse);
      vga_vsync = !vlow;
    end
  endtask

  task automatic runFrame(input int nlines, input int bad_line, input int bad_len, input int bad_pulse);
    for (int l = 0; l < nlines; l++) begin
      if (l == bad_line) applyStimulus(bad_len, bad_pulse, l < VP);
      else               applyStimulus(HT, HP, l < VP);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    resetbutton = 1'b1;
    repeat (2) @(negedge clk);
    resetbutton = 1'b0;
  endtask

  task automatic clearStats();
    clear_gen++;
  endtask

  initial begin
    resetbutton = 1'b1;
    vga_hsync   = 1'b1;
    vga_vsync   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_de", int'(de), 0);
    checkOutput("rst_pix_x", int'(pix_x), 0);
    checkOutput("rst_pix_y", int'(pix_y), 0);
    checkOutput("rst_frame_start", int'(frame_start), 0);
    checkOutput("rst_sync_err", int'(sync_err), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    resetbutton = 1'b0;

    $display("[TB] ideal timing, acquire and three locked frames");
    runFrame(VT, -1, 0, 0);
    checkOutput("unlocked_before_vfall", int'(locked), 0);
    clearStats();
    repeat (3) runFrame(VT, -1, 0, 0);
    checkOutput("ideal_locked", int'(locked), 1);
    checkOutput("ideal_fs_count", fs_count, 3);
    checkOutput("ideal_fs_period", fs_period, HT * VT);
    checkOutput("ideal_fs_offset", fs_off, 3);
    checkOutput("ideal_de_total", de_total, 3 * HD * VD);
    checkOutput("ideal_de_rise_offset", de_rise_off, 3 + HP + HB);
    checkOutput("ideal_pix_x_max", x_max, HD - 1);
    checkOutput("ideal_pix_y_max", y_max, VD - 1);
    checkOutput("ideal_pix_sequence_errors", pix_bad, 0);
    checkOutput("ideal_err_pulses", err_pulses, 0);
    checkOutput("ideal_err_count", int'(err_count), 0);

    $display("[TB] one long line while locked");
    clearStats();
    runFrame(VT, 3, HT + 1, HP);
    checkOutput("longline_err_pulses", err_pulses, 1);
    checkOutput("longline_err_offset", err_off, 3);
    checkOutput("longline_err_count", int'(err_count), 1);
    checkOutput("longline_locked", int'(locked), 0);
    checkOutput("longline_fs_count", fs_count, 1);
    runFrame(VT, -1, 0, 0);
    checkOutput("longline_relocked", int'(locked), 1);
    checkOutput("longline_relock_fs", fs_count, 2);

    $display("[TB] short hsync pulse while locked");
    pulseReset();
    checkOutput("reset_clears_err_count", int'(err_count), 0);
    runFrame(VT, -1, 0, 0);
    clearStats();
    runFrame(VT, 5, HT, HP - 1);
    checkOutput("shortpulse_err_pulses", err_pulses, 1);
    checkOutput("shortpulse_err_count", int'(err_count), 1);
    checkOutput("shortpulse_locked", int'(locked), 0);

    $display("[TB] short frame while locked");
    pulseReset();
    runFrame(VT, -1, 0, 0);
    runFrame(VT, -1, 0, 0);
    clearStats();
    runFrame(VT - 1, -1, 0, 0);
    applyStimulus(HT, HP, 1'b1);
    applyStimulus(HT, HP, 1'b1);
    checkOutput("shortframe_err_pulses", err_pulses, 1);
    checkOutput("shortframe_err_offset", err_off, 3);
    checkOutput("shortframe_fs_count", fs_count, 1);
    checkOutput("shortframe_locked", int'(locked), 0);
    checkOutput("shortframe_err_count", int'(err_count), 1);

    $display("[TB] hsync stuck high past the timeout");
    pulseReset();
    runFrame(VT, -1, 0, 0);
    runFrame(VT, -1, 0, 0);
    clearStats();
    applyStimulus(HT, HP, 1'b1);
    applyStimulus(140, HP, 1'b1);
    checkOutput("timeout_locked", int'(locked), 0);
    checkOutput("timeout_de", int'(de), 0);
    checkOutput("timeout_err_count", int'(err_count), 0);
    checkOutput("timeout_err_pulses", err_pulses, 0);
    for (int l = 2; l < 6; l++) applyStimulus(HT, HP, 1'b0);
    checkOutput("timeout_search_no_err", err_pulses, 0);

    $display("[TB] 300 short lines then reset mid-line");
    pulseReset();
    runFrame(VT, -1, 0, 0);
    runFrame(VT, -1, 0, 0);
    clearStats();
    repeat (300) applyStimulus(HT - 1, HP, 1'b0);
    applyStimulus(20, HP, 1'b0);
    checkOutput("saturate_err_pulses", err_pulses, 300);
    checkOutput("saturate_err_count", int'(err_count), 255);
    checkOutput("saturate_locked", int'(locked), 0);
    #2 resetbutton = 1'b1;
    #1;
    checkOutput("async_rst_err_count", int'(err_count), 0);
    checkOutput("async_rst_locked", int'(locked), 0);
    checkOutput("async_rst_de", int'(de), 0);
    checkOutput("async_rst_pix_x", int'(pix_x), 0);
    checkOutput("async_rst_pix_y", int'(pix_y), 0);
    checkOutput("async_rst_sync_err", int'(sync_err), 0);
    checkOutput("async_rst_frame_start", int'(frame_start), 0);
    clearStats();
    @(negedge clk);
    resetbutton = 1'b0;
    applyStimulus(18, 0, 1'b0);
    repeat (3) applyStimulus(HT, HP, 1'b0);
    checkOutput("post_reset_first_fall_no_err", err_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
